// File: rtl/decode_stage_pkg.sv
// Shared codes for the decode stage: base opcodes, ALU operation codes,
// immediate formats and the bundle of decoded control flags.
package decode_stage_pkg;

    // Base RV32I/RV64I major opcodes (inst[6:0], low two bits always 11)
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // ALU operation = {bit3, funct3}; bit3 selects SUB/SRA variants
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    // Immediate layouts of the base instruction formats
    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Control flags produced by the decoder for one instruction
    typedef struct packed {
        logic [3:0] alu_op;
        logic       use_imm;
        logic       reg_write;
        logic       ctrl;
        logic       illegal;
    } dec_ctrl_t;

    // Branches compare in the ALU: equality by subtraction, ordering by set-less-than
    function automatic logic [3:0] branch_alu_op(input logic [2:0] funct3);
        logic [3:0] op;
        case (funct3[2:1])
            2'b00:   op = ALU_SUB;   // BEQ / BNE
            2'b10:   op = ALU_SLT;   // BLT / BGE
            2'b11:   op = ALU_SLTU;  // BLTU / BGEU
            default: op = ALU_ADD;   // reserved branch funct3
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// The decode stage uses the slave view; its environment uses the master view.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    // fetch -> decode
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    // pipeline control from execute
    logic            flush;
    logic            resolve;

    // decode -> execute
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic [3:0]      out_alu_op;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic            out_use_imm;
    logic            out_reg_write;
    logic            out_ctrl;
    logic            out_illegal;
    logic            shadow;

    modport master (
        output in_valid, in_inst, in_pc, flush, resolve, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_alu_op, out_imm,
               out_rd, out_rs1, out_rs2, out_use_imm, out_reg_write,
               out_ctrl, out_illegal, shadow
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, resolve, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_alu_op, out_imm,
               out_rd, out_rs1, out_rs2, out_use_imm, out_reg_write,
               out_ctrl, out_illegal, shadow
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: extracts the immediate of a given format from an
// instruction word and sign-extends it (inst[31]) to XLEN bits.
// Purely combinational so the branch unit can reuse it.
module decode_stage_imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;
    logic               unused_opcode_bits;

    // The opcode field never contributes to an immediate
    assign unused_opcode_bits = ^inst[6:0];

    // Assemble the 32-bit immediate for the requested format
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;  // R-type carries no immediate
        endcase
    end

    // Signed size cast replicates bit 31 up to XLEN (no-op for XLEN = 32)
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage between fetch and execute.
// Decodes one instruction per cycle into a single registered output slot with
// valid/ready on both sides, and holds fetch off for a bounded branch shadow
// after each control transfer (released early by resolve, killed by flush).
// XLEN must be 32 or 64; SHADOW_MAX = 0 disables the shadow entirely.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHADOW_MAX = 3
) (
    input logic           clock,
    input logic           reset_n,
    decode_stage_if.slave bus
);

    // A zero-width counter is not representable, so keep at least one bit
    localparam int CNT_W = (SHADOW_MAX > 0) ? $clog2(SHADOW_MAX + 1) : 1;

    // ---------------------------------------------------------------
    // Instruction fields
    // ---------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       rd_nonzero;

    assign opcode     = bus.in_inst[6:0];
    assign funct3     = bus.in_inst[14:12];
    assign rd         = bus.in_inst[11:7];
    assign rd_nonzero = (rd != 5'd0);

    // ---------------------------------------------------------------
    // Combinational decode
    // ---------------------------------------------------------------
    dec_ctrl_t       dec;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] dec_imm;

    // Map the opcode to ALU op, immediate format and control flags
    always_comb begin
        dec = '{alu_op: ALU_ADD, use_imm: 1'b1, reg_write: 1'b0, ctrl: 1'b0, illegal: 1'b0};
        fmt = IMM_R;
        case (opcode)
            OPC_OP: begin
                dec.alu_op    = {bus.in_inst[30], funct3};
                dec.use_imm   = 1'b0;
                dec.reg_write = rd_nonzero;
            end
            OPC_OP_IMM: begin
                // inst[30] is part of the immediate except for SRAI, so ADDI never becomes SUB
                dec.alu_op    = {bus.in_inst[30] & (funct3 == 3'b101), funct3};
                dec.reg_write = rd_nonzero;
                fmt           = IMM_I;
            end
            OPC_LOAD: begin
                dec.reg_write = rd_nonzero;
                fmt           = IMM_I;
            end
            OPC_STORE: begin
                fmt = IMM_S;
            end
            OPC_BRANCH: begin
                dec.alu_op  = branch_alu_op(funct3);
                dec.use_imm = 1'b0;
                dec.ctrl    = 1'b1;
                fmt         = IMM_B;
            end
            OPC_JAL: begin
                dec.reg_write = rd_nonzero;
                dec.ctrl      = 1'b1;
                fmt           = IMM_J;
            end
            OPC_JALR: begin
                dec.reg_write = rd_nonzero;
                dec.ctrl      = 1'b1;
                fmt           = IMM_I;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.reg_write = rd_nonzero;
                fmt           = IMM_U;
            end
            default: begin
                // Covers inst[1:0] != 11 too, since those bits are part of the opcode
                dec.illegal = 1'b1;
            end
        endcase
    end

    decode_stage_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .inst(bus.in_inst),
        .fmt (fmt),
        .imm (dec_imm)
    );

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic             out_valid_q;
    logic             shadow_q;
    logic [CNT_W-1:0] shadow_cnt_q;
    logic             in_ready;
    logic             accept;
    logic             start_shadow;

    // The slot can take a new word when empty or draining, unless a shadow or flush blocks fetch
    assign in_ready     = (!out_valid_q | bus.out_ready) & !shadow_q & !bus.flush;
    assign accept       = bus.in_valid & in_ready;
    assign start_shadow = accept & dec.ctrl & (SHADOW_MAX > 0);

    // ---------------------------------------------------------------
    // Output slot
    // ---------------------------------------------------------------
    logic [31:0]     inst_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rd_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    dec_ctrl_t       ctrl_q;

    // Load the slot on accept; otherwise hold so a stalled slot stays bit-stable
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            inst_q      <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            ctrl_q      <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            inst_q      <= bus.in_inst;
            pc_q        <= bus.in_pc;
            imm_q       <= dec_imm;
            rd_q        <= rd;
            rs1_q       <= bus.in_inst[19:15];
            rs2_q       <= bus.in_inst[24:20];
            ctrl_q      <= dec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Branch shadow
    // ---------------------------------------------------------------

    // Count down the shadow after a control transfer; resolve or flush ends it early
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q     <= 1'b0;
            shadow_cnt_q <= '0;
        end else if (bus.flush) begin
            shadow_q     <= 1'b0;
            shadow_cnt_q <= '0;
        end else if (shadow_q) begin
            if (bus.resolve || shadow_cnt_q == CNT_W'(1)) begin
                shadow_q     <= 1'b0;
                shadow_cnt_q <= '0;
            end else begin
                shadow_cnt_q <= shadow_cnt_q - CNT_W'(1);
            end
        end else if (start_shadow) begin
            shadow_q     <= 1'b1;
            shadow_cnt_q <= CNT_W'(SHADOW_MAX);
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_inst      = inst_q;
    assign bus.out_pc        = pc_q;
    assign bus.out_alu_op    = ctrl_q.alu_op;
    assign bus.out_imm       = imm_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_rs1       = rs1_q;
    assign bus.out_rs2       = rs2_q;
    assign bus.out_use_imm   = ctrl_q.use_imm;
    assign bus.out_reg_write = ctrl_q.reg_write;
    assign bus.out_ctrl      = ctrl_q.ctrl;
    assign bus.out_illegal   = ctrl_q.illegal;
    assign bus.shadow        = shadow_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised RV32I/RV64I decode stage that sits between fetch and execute.
- Decodes all base opcode formats: ALU op, full per-format immediate, register indices, control flags.
- Registers the result into one output slot with valid/ready handshakes on both sides.
- Stalls fetch for a bounded branch shadow after any control-transfer instruction, released early by execute's resolve pulse or by a flush.

Parameters:
XLEN, 32, datapath width of pc and immediate (legal: 32 or 64)
SHADOW_MAX, 3, watchdog cycles the shadow may last after a control transfer (0 = no shadow)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  decode accepts this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction address
flush  in  1  kill held output and shadow
resolve  in  1  execute resolved the pending control transfer
out_valid  out  1  decoded slot valid
out_ready  in  1  execute consumes slot
out_inst  out  32  registered instruction
out_pc  out  XLEN  registered pc
out_alu_op  out  4  ALU operation
out_imm  out  XLEN  sign-extended immediate
out_rd / out_rs1 / out_rs2  out  5 each  register indices
out_use_imm  out  1  operand B is the immediate
out_reg_write  out  1  writes rd
out_ctrl  out  1  BRANCH/JAL/JALR
out_illegal  out  1  unrecognised encoding
shadow  out  1  control-transfer stall active

Behaviour:
- Reset (async, reset_n low): all out_* = 0 (out_alu_op = ADD = 4'b0000), out_valid = 0, shadow = 0, counter = 0.
- in_ready = (!out_valid | out_ready) & !shadow & !flush (combinational).
- Accept = in_valid & in_ready.
  - Decoded fields load on the next edge; out_valid = 1. Latency is 1 cycle.
  - Back-to-back acceptance gives full throughput.
- Consume without accept: out_valid clears.
- Stall (out_valid & !out_ready): every out_* holds bit-stable.
- Flush has highest priority:
  - next edge out_valid = 0, shadow = 0, counter = 0;
  - nothing is accepted in the flush cycle.
- Shadow control:
  - Accepting a control instruction with SHADOW_MAX > 0 sets shadow = 1 and counter = SHADOW_MAX.
  - While shadow is set, the counter decrements each cycle.
  - Shadow clears on the edge where the counter is 1, or on any cycle with resolve = 1.
  - Resolve while shadow = 0 is ignored.
  - Counter width is clog2(SHADOW_MAX+1).
- ALU op = {bit3, funct3}:
  - OP: {inst[30], funct3}.
  - OP_IMM: {inst[30] & (funct3 == 101), funct3}; SRAI keeps bit3, ADDI never gets SUB.
  - BRANCH: BEQ/BNE -> SUB (1000); BLT/BGE -> SLT (0010); BLTU/BGEU -> SLTU (0011).
  - All other opcodes: ADD.
- Immediate by format, sign bit inst[31] extended to XLEN:
  - I-type: LOAD, OP_IMM, JALR.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC; {inst[31:12], 12'b0}, sign-extended for XLEN = 64.
  - J-type: JAL.
  - R-type (OP): imm = 0.
- Control flags:
  - out_use_imm = 1 for every opcode except OP and BRANCH.
  - out_reg_write = 1 only when the opcode writes rd and rd != 0; never for BRANCH/STORE.
  - out_ctrl = 1 for BRANCH, JAL, JALR.
- Illegal encoding (inst[1:0] != 11, or opcode not in the base set):
  - out_illegal = 1, alu_op = ADD, reg_write = 0, ctrl = 0, no shadow;
  - the instruction still passes through the handshake.

Decomposition:
- Shared codes header/package holds:
  - opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC;
  - 4-bit ALU op codes: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND;
  - immediate-format enum: R, I, S, B, U, J.
- One combinational sub-module, imm_gen (inst, format -> XLEN immediate), reused later by the branch unit.
- Handshake and shadow logic stay in decode_stage.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready = 1: next cycle out_valid = 1, imm = 0xFFFFFFFF, rd = 1, alu_op = 0000, use_imm = 1, reg_write = 1.
- SRAI x2,x2,3 (0x40315113) then ADD x0,x1,x2 (0x00208033) back-to-back: alu_op 1101 then 0000; second has reg_write = 0; in_ready stays 1 throughout.
- BEQ x0,x0,-8 (0xFE000CE3), SHADOW_MAX = 3, no resolve:
  - imm = 0xFFFFFFF8, alu_op = 1000, ctrl = 1;
  - shadow = 1 and in_ready = 0 for exactly 3 cycles.
  - Repeat with resolve asserted 1 cycle after accept: shadow drops after 1 cycle.
- out_ready = 0 for 4 cycles with in_valid held: outputs bit-stable, in_ready = 0, no instruction lost or duplicated after out_ready rises.
- Flush during stall with shadow active: next cycle out_valid = 0, shadow = 0; flush and resolve in the same cycle behaves as flush.
- Word 0x00000000 -> out_illegal = 1, reg_write = 0. Separately, assert reset_n low mid-shadow: all outputs 0 immediately, without waiting for a clock edge.
